// File: rtl/hdc_job_arbiter.sv
// Round-robin arbiter/sequencer sharing one horizontal-distance core among N requesters.
// One job in flight; accept -> start -> wait (watchdog) -> respond; min accept-to-response 3 cycles.
module hdc_job_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid_i,
  input  logic [16*N-1:0] req_v_i,
  input  logic [16*N-1:0] req_x_i,
  output logic [N-1:0]    req_ready_o,
  output logic            resp_valid_o,
  output logic [2:0]      resp_id_o,
  output logic [15:0]     resp_result_o,
  output logic            resp_err_o,
  output logic            busy_o,
  output logic [15:0]     job_count_o,
  output logic [15:0]     core_v_o,
  output logic [15:0]     core_x_o,
  output logic            core_start_o,
  output logic            core_reset_o,
  input  logic            core_done_i,
  input  logic [15:0]     core_result_i
);

  localparam int            CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [2:0]    LAST_RST  = 3'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ABORT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    last_grant_q, id_q, resp_id_q;
  logic [15:0]   op_v_q, op_x_q, res_q, job_cnt_q;
  logic          err_q, done_q;
  logic [CW-1:0] wait_cnt_q;

  logic [N-1:0]  grant_oh;
  logic [2:0]    win_idx;
  logic          win_found;
  logic [3:0]    cand;
  logic [15:0]   sel_v, sel_x;
  logic          complete;

  // Rotating priority: candidates visited in order last_grant+1, +2, ... (mod N).
  always_comb begin
    grant_oh  = '0;
    win_idx   = last_grant_q;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, last_grant_q} + 4'(k + 1);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      for (int i = 0; i < N; i++) begin
        if (!win_found && req_valid_i[i] && cand == 4'(i)) begin
          win_found   = 1'b1;
          win_idx     = 3'(i);
          grant_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_v = '0;
    sel_x = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_oh[i]) begin
        sel_v = req_v_i[16*i +: 16];
        sel_x = req_x_i[16*i +: 16];
      end
    end
  end

  // Edge detect so a done level left over from the previous job never completes this one.
  assign complete = core_done_i & ~done_q;

  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    core_start_o = 1'b0;
    resp_valid_o = 1'b0;
    busy_o       = 1'b0;
    core_reset_o = reset;
    case (state_q)
      S_IDLE: begin
        if (win_found) state_d = S_START;
        if (!reset) req_ready_o = grant_oh;
      end
      S_START: begin
        state_d      = S_WAIT;
        core_start_o = !reset;
        busy_o       = !reset;
      end
      S_WAIT: begin
        busy_o = !reset;
        if (complete) state_d = S_RESP;
        else if (wait_cnt_q == WAIT_LAST) state_d = S_ABORT;
      end
      S_ABORT: begin
        state_d      = S_RESP;
        core_reset_o = 1'b1;
        busy_o       = !reset;
      end
      S_RESP: begin
        state_d      = S_IDLE;
        resp_valid_o = !reset;
        busy_o       = !reset;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_RST;
      op_v_q       <= '0;
      op_x_q       <= '0;
      id_q         <= '0;
      resp_id_q    <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      wait_cnt_q   <= '0;
      job_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= core_done_i;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            op_v_q       <= sel_v;
            op_x_q       <= sel_x;
            id_q         <= win_idx;
            last_grant_q <= win_idx;
          end
        end
        S_START: wait_cnt_q <= '0;
        S_WAIT: begin
          if (complete) begin
            res_q     <= core_result_i;
            err_q     <= 1'b0;
            resp_id_q <= id_q;
          end else if (wait_cnt_q != WAIT_LAST) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        S_ABORT: begin
          res_q     <= '0;
          err_q     <= 1'b1;
          resp_id_q <= id_q;
        end
        S_RESP: begin
          if (!err_q) job_cnt_q <= job_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Response fields are only reloaded on the way into RESP, so they hold between responses.
  assign resp_id_o     = resp_id_q;
  assign resp_result_o = res_q;
  assign resp_err_o    = err_q;
  assign job_count_o   = job_cnt_q;
  assign core_v_o      = op_v_q;
  assign core_x_o      = op_x_q;

endmodule
